// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port arbiter between instruction fetch and load/store.
// Multi-byte accesses are split into byte cycles and reassembled little-endian.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_in,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] base;
    logic              serve_if;
    logic              mem_wr_q;
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;
    logic [31:0]       rdata_next;
    logic [1:0]        cap_idx;
    logic [2:0]        ls_n;
    logic              io_blocked;

    assign mem_wr = mem_wr_q & rdy_in;

    always_comb begin
        cap_idx    = cnt[1:0] - 2'd1;
        rdata_next = rbuf;
        rdata_next[{cap_idx, 3'b000} +: 8] = mem_din;
        case (ls_size)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
        io_blocked = ls_we && (ls_addr[17:16] == IO_SEL) && io_buffer_full;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            nbytes   <= '0;
            base     <= '0;
            serve_if <= 1'b0;
            mem_wr_q <= 1'b0;
            wbuf     <= '0;
            rbuf     <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_inst  <= '0;
            ls_rdata <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if_done  <= 1'b0;
                    ls_done  <= 1'b0;
                    mem_wr_q <= 1'b0;
                    // A pending but throttled MEM request still blocks IF.
                    if (ls_req) begin
                        if (!io_blocked) begin
                            base     <= ls_addr;
                            mem_a    <= ls_addr;
                            cnt      <= 3'd1;
                            nbytes   <= ls_n;
                            serve_if <= 1'b0;
                            rbuf     <= '0;
                            wbuf     <= ls_wdata;
                            if (ls_we) begin
                                state    <= WRITE;
                                mem_wr_q <= 1'b1;
                                mem_dout <= ls_wdata[7:0];
                            end else begin
                                state <= READ;
                            end
                        end
                    end else if (if_req && !flush_in) begin
                        base     <= if_addr;
                        mem_a    <= if_addr;
                        cnt      <= 3'd1;
                        nbytes   <= 3'd4;
                        serve_if <= 1'b1;
                        rbuf     <= '0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (serve_if && flush_in) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        rbuf <= rdata_next;
                        if (cnt == nbytes) begin
                            if (serve_if) begin
                                if_inst <= rdata_next;
                                if_done <= 1'b1;
                            end else begin
                                ls_rdata <= rdata_next;
                                ls_done  <= 1'b1;
                            end
                            state <= DONE;
                        end else begin
                            mem_a <= base + ADDR_W'(cnt);
                            cnt   <= cnt + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == nbytes) begin
                        mem_wr_q <= 1'b0;
                        ls_done  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mem_a    <= base + ADDR_W'(cnt);
                        mem_dout <= wbuf[{cnt[1:0], 3'b000} +: 8];
                        cnt      <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    if_done <= 1'b0;
                    ls_done <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide RAM/IO port between instruction fetch (IF) and the load/store unit (MEM stage).
- Serialises each 1/2/4-byte access into byte cycles and reassembles read data little-endian.
- Returns one-cycle done pulses. The MEM stage uses ls_done to release its stall request and hand data to MEM_WB.
- MEM requests have priority over IF. Arbitration is non-preemptive once a transfer starts.

Parameters:
- ADDR_W, 32, width of all addresses.
- IO_SEL, 2'b11, value of addr[17:16] that marks the IO region (store throttled by io_buffer_full).

Ports:
- clk_in  input  1  clock; all logic on posedge.
- rst_in  input  1  synchronous active-low reset; rst_in==0 at a posedge resets.
- rdy_in  input  1  global ready; 0 freezes the block.
- io_buffer_full  input  1  IO write buffer full.
- mem_din  input  8  RAM read byte, for the address driven in the previous cycle.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_W  RAM byte address.
- mem_wr  output  1  1 = write, 0 = read.
- if_req  input  1  fetch request, level, held until if_done.
- if_addr  input  ADDR_W  fetch address (word).
- flush_in  input  1  branch-mispredict flush; aborts fetch.
- if_done  output  1  one-cycle pulse: if_inst valid.
- if_inst  output  32  fetched word.
- ls_req  input  1  load/store request, level, held until ls_done.
- ls_we  input  1  1 = store, 0 = load.
- ls_size  input  2  00 = byte, 01 = half, 10 = word; 11 treated as word.
- ls_addr  input  ADDR_W  load/store base address.
- ls_wdata  input  32  store data; byte k = bits [8k+7:8k].
- ls_done  output  1  one-cycle pulse: load/store complete.
- ls_rdata  output  32  load data, zero-extended (sign extension is done by the MEM stage).

Behaviour:
- Reset (rst_in==0 at an edge): state IDLE; counter 0; mem_a, mem_dout, if_inst, ls_rdata = 0; mem_wr, if_done, ls_done = 0.
  - Applies mid-transfer; the partial transfer is discarded with no done pulse.
- rdy_in==0: state, counter, all registers and outputs hold; no capture of mem_din.
  - mem_wr output is gated: mem_wr = mem_wr_q & rdy_in.
  - On resume, the current byte is re-presented once.
- All outputs are registered except the mem_wr gate above.
- States: IDLE, READ, WRITE, DONE.
- IDLE acceptance at edge E0 (n = byte count 1/2/4):
  - ls_req=1 wins over if_req=1.
  - A store with ls_addr[17:16]==IO_SEL is not accepted while io_buffer_full=1; if_req is NOT accepted in its place while ls_req=1 is pending.
  - if_req is accepted only if flush_in=0 at that edge.
  - After E0: mem_a = base, counter = 1.
- READ:
  - At edge Ek (1<=k<n): capture mem_din into byte k-1; drive mem_a = base+k.
  - At edge En: capture byte n-1; raise if_done or ls_done for one cycle with full data; go to DONE.
  - Done is visible n cycles after the acceptance edge. Unused ls_rdata bytes = 0.
- WRITE:
  - After E0: mem_wr=1, mem_dout = byte0.
  - After Ek (k<n): mem_a = base+k, mem_dout = byte k.
  - At En: mem_wr=0, ls_done=1, go to DONE. Latency n cycles.
- DONE: one cycle; done pulse visible; requests are ignored; next state IDLE, with done deasserted.
  - Requesters drop req at the edge ending the done cycle.
  - Back-to-back transfers are separated by exactly one DONE cycle plus the IDLE acceptance edge.
- flush_in=1 sampled while READ serves IF (including at En): return to IDLE, no if_done, mem_a held, if_inst unchanged.
- flush_in is ignored while serving MEM and in WRITE.
- Address arithmetic is base+k modulo 2^ADDR_W (wraps at the top of the address space).
- mem_wr=0 in IDLE and DONE.

Test Plan:
- Word fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> mem_a sequence 0x100..0x103; if_done high exactly 4 cycles after acceptance edge; if_inst=0x00100513.
- Priority: if_req and ls_req (load byte, addr 0x2000, RAM=0xFF) both raised in IDLE -> load served first, ls_rdata=0x000000FF; fetch starts after DONE; no overlap.
- Half store: ls_we=1, ls_size=01, ls_addr=0x1FFE, ls_wdata=0xAABBCCDD -> writes 0xDD@0x1FFE, 0xCC@0x1FFF, mem_wr high 2 cycles, ls_done after 2 cycles.
- IO throttle: store to 0x30000 with io_buffer_full=1 for 5 cycles and if_req=1 -> no mem_wr, no fetch; io_buffer_full->0 -> store accepted next edge.
- Flush: fetch at 0x200, flush_in=1 at 2nd capture edge -> no if_done, state IDLE next cycle; a new fetch at 0x300 completes normally.
- rdy/reset: rdy_in=0 for 3 cycles mid-word read -> done delayed 3 cycles, data correct. rst_in=0 mid-store -> all outputs 0 next cycle, no ls_done.
